fir_out_fifo: RTL and testbench

Output buffer directly downstream of the fir core, in the core clock (clk2) domain. It captures every filtered sample presented as a valid pulse plus a 16-bit word. It stores the samples in a show-ahead FIFO and hands them to the consumer (serializer/host readout) over a valid/ready handshake. It also detects and counts samples lost when the consumer stalls.

---
 rtl/fir_pkg.sv | 7 +
 rtl/fir_fifo_ram.sv | 33 +++
 rtl/fir_out_fifo.sv | 109 ++++++++++
 tb/tb_fir_out_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and depths for the fir datapath and its output buffer
package fir_pkg;
  localparam int FIR_DW         = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_AW_DEF    = 4;
  localparam int DROP_CNT_W     = 8;
endpackage

// File: rtl/fir_fifo_ram.sv
// rtl/fir_fifo_ram.sv - register array with one synchronous write port and one asynchronous read port
// Ports:
//   clk   - write clock
//   we    - write enable; wdata lands in mem[waddr] on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - mem[raddr], combinational
module fir_fifo_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Storage is deliberately not reset; occupancy tracking decides what is valid.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - show-ahead output FIFO after the fir core with overflow detection
// Ports:
//   clk2      - core clock
//   rstn      - asynchronous active-low reset
//   valid_in  - sample strobe from the fir core
//   din       - sample word, taken only when valid_in=1
//   out_ready - consumer accepts the head word this cycle
//   clr_ovf   - clears overflow and drop_cnt (a same-cycle drop wins)
//   out_valid - head word available
//   dout      - head word, 0 when empty
//   count     - occupancy 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
//   overflow  - sticky flag, set on any dropped sample
//   drop_cnt  - dropped samples, saturating
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = FIFO_AW_DEF
) (
  input  logic                  clk2,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [DW-1:0]         din,
  input  logic                  out_ready,
  input  logic                  clr_ovf,
  output logic                  out_valid,
  output logic [DW-1:0]         dout,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [AW:0]           COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX   = '1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] rdata;
  logic          pop;
  logic          push;
  logic          drop;

  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign out_valid = ~empty;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = valid_in & (~full | pop);
  assign drop = valid_in & full & ~pop;

  fir_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk2),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign dout = empty ? '0 : rdata;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear counts as the first event after the clear.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_fifo.sv
// tb/tb_fir_out_fifo.sv - scoreboard bench for fir_out_fifo
module tb_fir_out_fifo;
  import fir_pkg::*;

  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic                  clk2 = 1'b0;
  logic                  rstn;
  logic                  valid_in;
  logic [FIR_DW-1:0]     din;
  logic                  out_ready;
  logic                  clr_ovf;
  logic                  out_valid;
  logic [FIR_DW-1:0]     dout;
  logic [FIFO_AW_DEF:0]  count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  fir_out_fifo dut (
    .clk2      (clk2),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .din       (din),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .dout      (dout),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #50 clk2 = ~clk2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FIR_DW-1:0] sb[$];
  int                m_count = 0;
  int                m_drop  = 0;
  logic              m_ovf   = 1'b0;
  int                n_popped = 0;
  logic [FIR_DW-1:0] last_pop;

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_drop  = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock cycle: drive, compare the popped head before the edge, update the model, check state after.
  task automatic cycle(input logic v, input logic [FIR_DW-1:0] d, input logic rdy, input logic clr);
    logic p, pu, dr;
    valid_in  = v;
    din       = d;
    out_ready = rdy;
    clr_ovf   = clr;
    p  = (m_count != 0) && rdy;
    pu = v && ((m_count < DEPTH) || p);
    dr = v && (m_count == DEPTH) && !p;
    if (p) begin
      n_tests++;
      if (dout !== sb[0]) begin
        n_fail++;
        $display("FAIL pop_data: got %h expected %h", dout, sb[0]);
      end
      last_pop = sb.pop_front();
      n_popped++;
    end
    if (pu) sb.push_back(d);
    m_count = m_count + (pu ? 1 : 0) - (p ? 1 : 0);
    if (clr) begin
      m_ovf  = dr;
      m_drop = dr ? 1 : 0;
    end else if (dr) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge clk2);
    #1;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    n_tests++;
    if (count !== 5'(m_count) || out_valid !== (m_count != 0)) begin
      n_fail++;
      $display("FAIL occupancy: count=%0d out_valid=%b expected count=%0d", count, out_valid, m_count);
    end
    n_tests++;
    if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
      n_fail++;
      $display("FAIL ovf_state: overflow=%b drop_cnt=%0d expected %b %0d", overflow, drop_cnt, m_ovf, m_drop);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid_in = 1'b0; din = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    @(posedge clk2); #1;
    valid_in = 1'b1; din = 16'h1234;
    @(posedge clk2); #1;
    valid_in = 1'b0;
    @(posedge clk2); #1;
    n_tests++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dout !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_fifo: out_valid=%b empty=%b full=%b count=%0d dout=%h expected 0 1 0 0 0000",
               out_valid, empty, full, count, dout);
    end
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ovf: overflow=%b drop_cnt=%0d expected 0 0", overflow, drop_cnt);
    end
    #20 rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
    n_tests++;
    if (dout !== 16'hA5A5 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL single_show_ahead: dout=%h count=%0d expected a5a5 1", dout, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (empty !== 1'b1 || dout !== 16'h0) begin
      n_fail++;
      $display("FAIL single_drain: empty=%b dout=%h expected 1 0000", empty, dout);
    end
    // out_ready while empty must not underflow
    cycle(1'b0, '0, 1'b1, 1'b0);
    // empty with valid_in and out_ready: no bypass, sample is stored
    cycle(1'b1, 16'h5A5A, 1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd1 || dout !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL no_bypass: count=%0d dout=%h expected 1 5a5a", count, dout);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    n_tests++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_full: full=%b count=%0d expected 1 16", full, count);
    end
    n_popped = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 16; i < 24; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (n_popped !== 24 || last_pop !== 16'h0017 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_order: popped=%0d last=%h empty=%b expected 24 0017 1", n_popped, last_pop, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd3 || count !== 5'd16 || dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL drop3: overflow=%b drop_cnt=%0d count=%0d dout=%h expected 1 3 16 0000",
               overflow, drop_cnt, count, dout);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_ovf: overflow=%b drop_cnt=%0d expected 0 0", overflow, drop_cnt);
    end
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    n_tests++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_saturate: drop_cnt=%0d overflow=%b expected 255 1", drop_cnt, overflow);
    end
    // clear and drop together: the drop wins
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
    n_tests++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_drop: drop_cnt=%0d overflow=%b expected 1 1", drop_cnt, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd16 || drop_cnt !== 8'd1 || dout !== 16'h0001) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d drop_cnt=%0d head=%h expected 16 1 0001", count, drop_cnt, dout);
    end
    n_popped = 0;
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (n_popped !== 16 || last_pop !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL beef_16th: popped=%0d last=%h expected 16 beef", n_popped, last_pop);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    #20 rstn = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b count=%0d empty=%b expected 0 0 1", out_valid, count, empty);
    end
    model_reset();
    #10 rstn = 1'b1;
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    n_tests++;
    if (dout !== 16'h7777 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: dout=%h count=%0d expected 7777 1", dout, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), (i % 3) == 2, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (empty !== 1'b1 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_drain: empty=%b left=%0d expected 1 0", empty, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
